rob_commit_ctrl: RTL
====================

Name: rob_commit_ctrl

Overview:
Head/tail controller and in-order commit engine for the reorder buffer storage array.
- Dispatch side: allocates entries at the tail and returns the tag.
- Read side: reads the head entry through one storage read port, retires it in order, and clears its storage cell through one storage write port.
- Drives the register-file write and the pipeline flush on an exception or an external redirect.

Parameters:
DEPTH, ROB_DEPTH (qu_common), number of ROB entries; power of two, at least 4.
XLEN, 32, result/register-file data width.

Ports:
clk  in  1  clock, all state updates on posedge.
rst  in  1  synchronous, active-high reset.
alloc_req  in  1  dispatch requests one entry.
alloc_gnt  out  1  request accepted this cycle.
alloc_tag  out  $clog2(DEPTH)  allocated entry index (the tail).
rob_full  out  1  no free entries.
rob_empty  out  1  no occupied entries.
head_rd_addr  out  $clog2(DEPTH)  storage read address, always the head.
head_rd_data  in  rob_cell_t  storage read data (combinational read).
clr_en  out  1  storage write enable used to clear the retired cell.
clr_addr  out  $clog2(DEPTH)  address of the cell to clear.
rf_wr_en  out  1  register-file write strobe.
rf_wr_addr  out  5  destination register.
rf_wr_data  out  XLEN  committed value.
commit_valid  out  1  one instruction retired (pulse).
commit_tag  out  $clog2(DEPTH)  tag of the retired entry.
flush_in  in  1  external redirect (branch mispredict).
flush_out  out  1  pipeline flush request (pulse).

Behaviour:
- rob_cell_t (qu_common) carries at least these fields: valid, ready, exc, rd (5b), value (XLEN).
- Dispatch writes valid=1, ready=0 at alloc_tag. Execute sets ready and value.
- State:
  - head and tail pointers, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - rob_full = (head index == tail index) and wrap bits differ.
  - rob_empty = head == tail.
- Reset:
  - head=tail=0.
  - FSM=RUN.
  - All registered outputs are 0: rf_wr_en, commit_valid, flush_out, rf_wr_addr, rf_wr_data, commit_tag.
- Allocation (combinational grant):
  - alloc_gnt = alloc_req & !rob_full & FSM==RUN & !flush_in.
  - alloc_tag = tail index.
  - tail increments at the next edge when alloc_gnt=1.
  - When full, alloc_gnt=0 even if a commit occurs the same cycle. No bypass.
- Commit condition: commit = FSM==RUN & !rob_empty & head_rd_data.valid & head_rd_data.ready.
  - head_rd_addr = head index, continuously.
  - On commit, clr_en=1 and clr_addr=head in the same cycle (combinational). head increments at the edge.
  - Registered outputs, 1-cycle latency after commit:
    - commit_valid=1, commit_tag=old head.
    - rf_wr_en=1 unless exc=1 or rd==0.
    - rf_wr_addr=rd, rf_wr_data=value.
  - At most one commit per cycle.
- Simultaneous alloc and commit: both pointers advance. Occupancy is unchanged.
- Exception commit (commit & exc):
  - Counts as a commit: commit_valid=1 next cycle, rf_wr_en=0.
  - flush_out=1 next cycle.
  - FSM moves to FLUSH.
- FSM:
  - RUN -> FLUSH when flush_in=1, or on an exception commit.
  - FLUSH (exactly one cycle):
    - head=tail=0, alloc_gnt=0, commit=0, clr_en=0.
    - Returns to RUN.
  - flush_out is a registered 1-cycle pulse, asserted for external flushes as well.
  - Stale cells are not cleared. Dispatch overwrites valid/ready on re-allocation.
- Priority:
  - rst overrides everything.
  - flush_in in RUN suppresses alloc that cycle. Commit still proceeds that cycle.
  - A flush in FLUSH is absorbed; no second pulse.
- Wrap-around: index bits roll from DEPTH-1 to 0 and the wrap bit toggles. Full and empty are distinguished only via the wrap bit.
- Mid-operation rst: all state returns to reset values at the edge. Outputs are 0 the next cycle.

Decomposition:
- qu_common holds rob_cell_t (valid, ready, exc, rd, value), ROB_DEPTH, rob_addr_t, and a rob_ptr_t (addr + wrap bit).
- The FSM enum rob_cmt_state_t {RUN, FLUSH} stays local to this module.
- One natural sub-module: rob_ptr, a wrap-bit pointer with inc and clr inputs, instantiated for head and tail.

Test Plan:
- Reset, then 16 alloc_req cycles (DEPTH=16) -> tags 0..15 granted. rob_full=1 after the 16th. The 17th request gives alloc_gnt=0.
- Alloc tag 0 and storage returns {valid=1, ready=1, rd=5, value=0xDEADBEEF} -> clr_en/clr_addr=0 same cycle. Next cycle: rf_wr_en=1, rf_wr_addr=5, rf_wr_data=0xDEADBEEF, commit_tag=0.
- Head entry has ready=0 for 3 cycles, then ready=1 -> no commit_valid for 3 cycles, commit exactly one cycle after ready rises. Entry with rd=0 commits with rf_wr_en=0 and commit_valid=1.
- Head at 15 with wrap=0, tail at 3 with wrap=1 -> commits 15, 0, 1, 2 in order. rob_empty=1 after the 4th commit, head index=3, wrap=1.
- Head entry exc=1 with alloc_req held high -> rf_wr_en=0, commit_valid=1, flush_out=1 next cycle. Then one FLUSH cycle with alloc_gnt=0. Then alloc_tag=0, rob_empty=1.
- flush_in pulsed while full with a committable head -> that commit is retired, pointers are 0 after FLUSH, a single flush_out pulse. rst asserted mid-stream -> all outputs are 0 the next cycle.

Source files
------------

// File: rtl/qu_common.sv
// Shared reorder-buffer types: storage cell layout, depth and wrap-bit pointer.
// Pure type/constant package, no logic.
package qu_common;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_AW    = $clog2(ROB_DEPTH);
  localparam int XLEN_W    = 32;

  typedef logic [ROB_AW-1:0] rob_addr_t;

  typedef struct packed {
    logic      wrap;
    rob_addr_t addr;
  } rob_ptr_t;

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic              exc;
    logic [4:0]        rd;
    logic [XLEN_W-1:0] value;
  } rob_cell_t;

endpackage

// File: rtl/rob_ptr.sv
// Circular pointer with a wrap bit above the index; clr wins over inc.
// Updates one cycle after inc/clr; never stalls.
module rob_ptr #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [AW-1:0] idx_o,
  output logic          wrap_o
);

  logic [AW:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign idx_o  = ptr_q[AW-1:0];
  assign wrap_o = ptr_q[AW];

endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB head/tail control with in-order single-entry commit, RF writeback and flush.
// Grant/clear are combinational; commit/RF/flush outputs register 1 cycle later; alloc stalls when full or flushing.
module rob_commit_ctrl
  import qu_common::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int XLEN  = XLEN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_req,
  output logic                     alloc_gnt,
  output logic [$clog2(DEPTH)-1:0] alloc_tag,
  output logic                     rob_full,
  output logic                     rob_empty,
  output logic [$clog2(DEPTH)-1:0] head_rd_addr,
  input  rob_cell_t                head_rd_data,
  output logic                     clr_en,
  output logic [$clog2(DEPTH)-1:0] clr_addr,
  output logic                     rf_wr_en,
  output logic [4:0]               rf_wr_addr,
  output logic [XLEN-1:0]          rf_wr_data,
  output logic                     commit_valid,
  output logic [$clog2(DEPTH)-1:0] commit_tag,
  input  logic                     flush_in,
  output logic                     flush_out
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [0:0] rob_cmt_state_t;
  localparam rob_cmt_state_t RUN   = 1'b0;
  localparam rob_cmt_state_t FLUSH = 1'b1;

  rob_cmt_state_t state_q, state_d;

  logic [AW-1:0] head_idx, tail_idx;
  logic          head_wrap, tail_wrap;
  logic          run;
  logic          commit;
  logic          exc_commit;
  logic          ptr_clr;

  logic            commit_valid_q, commit_valid_d;
  logic [AW-1:0]   commit_tag_q, commit_tag_d;
  logic            rf_wr_en_q, rf_wr_en_d;
  logic [4:0]      rf_wr_addr_q, rf_wr_addr_d;
  logic [XLEN-1:0] rf_wr_data_q, rf_wr_data_d;
  logic            flush_out_q, flush_out_d;

  rob_ptr #(.AW(AW)) u_head (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (commit),
    .clr_i  (ptr_clr),
    .idx_o  (head_idx),
    .wrap_o (head_wrap)
  );

  rob_ptr #(.AW(AW)) u_tail (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (alloc_gnt),
    .clr_i  (ptr_clr),
    .idx_o  (tail_idx),
    .wrap_o (tail_wrap)
  );

  assign run       = (state_q == RUN);
  assign ptr_clr   = !run;
  assign rob_empty = (head_idx == tail_idx) && (head_wrap == tail_wrap);
  assign rob_full  = (head_idx == tail_idx) && (head_wrap != tail_wrap);

  // No full-bypass: a same-cycle commit does not free a slot for this cycle's request.
  assign alloc_gnt = alloc_req && !rob_full && run && !flush_in;
  assign alloc_tag = tail_idx;

  assign head_rd_addr = head_idx;
  assign commit       = run && !rob_empty && head_rd_data.valid && head_rd_data.ready;
  assign exc_commit   = commit && head_rd_data.exc;
  assign clr_en       = commit;
  assign clr_addr     = head_idx;

  always_comb begin
    state_d        = RUN;
    flush_out_d    = 1'b0;
    commit_valid_d = commit;
    commit_tag_d   = commit_tag_q;
    rf_wr_en_d     = commit && !head_rd_data.exc && (head_rd_data.rd != 5'd0);
    rf_wr_addr_d   = rf_wr_addr_q;
    rf_wr_data_d   = rf_wr_data_q;
    if (commit) begin
      commit_tag_d = head_idx;
      rf_wr_addr_d = head_rd_data.rd;
      rf_wr_data_d = head_rd_data.value;
    end
    // A flush request arriving during FLUSH is absorbed by the single FLUSH cycle.
    if (run && (flush_in || exc_commit)) begin
      state_d     = FLUSH;
      flush_out_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      rf_wr_en_q     <= 1'b0;
      rf_wr_addr_q   <= '0;
      rf_wr_data_q   <= '0;
      flush_out_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      commit_valid_q <= commit_valid_d;
      commit_tag_q   <= commit_tag_d;
      rf_wr_en_q     <= rf_wr_en_d;
      rf_wr_addr_q   <= rf_wr_addr_d;
      rf_wr_data_q   <= rf_wr_data_d;
      flush_out_q    <= flush_out_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_tag   = commit_tag_q;
  assign rf_wr_en     = rf_wr_en_q;
  assign rf_wr_addr   = rf_wr_addr_q;
  assign rf_wr_data   = rf_wr_data_q;
  assign flush_out    = flush_out_q;

endmodule
